// File: rtl/sub_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// sub_div_ctrl_if
//   Request/result bundle between a requesting master and the sequential
//   restoring divider (sub_div_ctrl).
//   Signals:
//     start        master -> divider  request, accepted only while idle
//     dividend     master -> divider  unsigned dividend, sampled on accept
//     divisor      master -> divider  unsigned divisor, sampled on accept
//     busy         divider -> master  high while iterating
//     done         divider -> master  one-cycle pulse, results valid
//     quotient     divider -> master  unsigned quotient
//     remainder    divider -> master  unsigned remainder
//     div_by_zero  divider -> master  set together with done when divisor == 0
// -----------------------------------------------------------------------------
interface sub_div_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sub_div_ctrl.sv
// -----------------------------------------------------------------------------
// sub_div_ctrl
//   Sequential restoring divider. One (WIDTH+1)-bit ripple borrow-chain
//   subtract stage is reused once per quotient bit, MSB first; the final
//   borrow-out decides each quotient bit and whether the partial remainder
//   is restored.
//   Ports:
//     i_clk  rising-edge clock
//     i_rst  asynchronous active-high reset
//     bus    sub_div_ctrl_if.slave (start/operands in, busy/done/results out)
// -----------------------------------------------------------------------------
module sub_div_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sub_div_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;        // dividend shift register, fills with quotient bits
    logic [WIDTH-1:0] r_d;        // latched divisor
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [CW-1:0]    r_cnt;      // iterations completed
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_last;
    logic             w_div_zero;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_sub;      // {borrow_out, diff[WIDTH-1:0]}
    logic             w_bo;
    logic [WIDTH-1:0] w_r_step;
    logic [WIDTH-1:0] w_q_step;

    // Ripple borrow-chain a - b with borrow-in 0. The top diff bit is not
    // produced: whenever it would be kept (no borrow) it is zero because R < D.
    function automatic logic [WIDTH:0] sub_borrow(input logic [WIDTH:0] a,
                                                  input logic [WIDTH:0] b);
        logic [WIDTH-1:0] d;
        logic             br;
        br = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        br = (~a[WIDTH] & b[WIDTH]) | (~(a[WIDTH] ^ b[WIDTH]) & br);
        return {br, d};
    endfunction

    assign w_div_zero = (bus.divisor == {WIDTH{1'b0}});
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_trial    = {r_rem, r_q[WIDTH-1]};
    assign w_sub      = sub_borrow(w_trial, {1'b0, r_d});
    assign w_bo       = w_sub[WIDTH];
    // Borrow means the trial was smaller than D: restore and shift in a 0.
    assign w_r_step   = w_bo ? w_trial[WIDTH-1:0] : w_sub[WIDTH-1:0];
    assign w_q_step   = {r_q[WIDTH-2:0], ~w_bo};

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode, looked up on the next state so the flags can be registered
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN:   w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered handshake flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Datapath: operand capture, one restoring iteration per RUN cycle, result latch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q       <= {WIDTH{1'b0}};
            r_d       <= {WIDTH{1'b0}};
            r_rem     <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_quot    <= {WIDTH{1'b0}};
            r_rem_out <= {WIDTH{1'b0}};
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_q   <= bus.dividend;
                        r_d   <= bus.divisor;
                        r_rem <= {WIDTH{1'b0}};
                        r_cnt <= {CW{1'b0}};
                        if (w_div_zero) begin
                            r_quot    <= {WIDTH{1'b1}};
                            r_rem_out <= bus.dividend;
                            r_dbz     <= 1'b1;
                        end else begin
                            r_dbz     <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_step;
                    r_rem <= w_r_step;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quot    <= w_q_step;
                        r_rem_out <= w_r_step;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem_out;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sub_div_ctrl
//   Directed self-checking bench for sub_div_ctrl (WIDTH = 4).
// -----------------------------------------------------------------------------
module tb_sub_div_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sub_div_ctrl_if #(.WIDTH(4)) bus ();

    sub_div_ctrl #(.WIDTH(4)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_q"},    32'(bus.quotient), 32'd0);
        chk({tag, "_r"},    32'(bus.remainder), 32'd0);
        chk({tag, "_dbz"},  32'(bus.div_by_zero), 32'd0);
    endtask

    // Called in IDLE, #1 after a rising edge. Returns in IDLE, #1 after an edge.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic edbz, input int elat);
        int lat;
        int nbusy;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        lat   = 0;
        nbusy = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},  32'(lat), 32'(elat));
        chk({tag, "_busy"}, 32'(nbusy), 32'(elat));
        chk({tag, "_q"},    32'(bus.quotient), 32'(eq));
        chk({tag, "_r"},    32'(bus.remainder), 32'(er));
        chk({tag, "_dbz"},  32'(bus.div_by_zero), 32'(edbz));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_holdq"}, 32'(bus.quotient), 32'(eq));
    endtask

    initial begin
        int ndone;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor  = 4'd0;
        #2 rst = 1'b1;
        #1 chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // 13/3
        run_op("t1_13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);

        // Corners
        run_op("t2_15_1",  4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
        run_op("t2_15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4);
        run_op("t2_0_7",   4'd0,  4'd7, 4'd0,  4'd0, 1'b0, 4);
        run_op("t2_3_9",   4'd3,  4'd9, 4'd0,  4'd3, 1'b0, 4);

        // Divide by zero
        run_op("t3_7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 0);

        // start held high for 10 cycles; operands changed mid-RUN
        bus.start    = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor  = 4'd2;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus.dividend = 4'd15;
                bus.divisor  = 4'd1;
            end
            if (i == 9) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("t4_first_at", 32'(i), 32'd4);
                    chk("t4_first_q",  32'(bus.quotient), 32'd4);
                    chk("t4_first_r",  32'(bus.remainder), 32'd1);
                end else begin
                    chk("t4_second_at", 32'(i), 32'd10);
                    chk("t4_second_q",  32'(bus.quotient), 32'd15);
                    chk("t4_second_r",  32'(bus.remainder), 32'd0);
                end
            end
        end
        chk("t4_ndone", 32'(ndone), 32'd2);

        // Reset during the 2nd RUN cycle
        bus.start    = 1'b1;
        bus.dividend = 4'd13;
        bus.divisor  = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk_outputs_zero("t5_rst");
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        @(negedge clk) rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'd0);
        run_op("t5_10_4", 4'd10, 4'd4, 4'd2, 4'd2, 1'b0, 4);

        // Exhaustive sweep against a reference division
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    run_op($sformatf("sw_%0d_%0d", a, b), 4'(a), 4'(b),
                           4'd15, 4'(a), 1'b1, 0);
                end else begin
                    run_op($sformatf("sw_%0d_%0d", a, b), 4'(a), 4'(b),
                           4'(a / b), 4'(a % b), 1'b0, 4);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
